// File: rtl/wb_pipe_buffer.sv
// MEM->WB pipeline buffer: DEPTH-stage shift of writeback bundles with valid, stall, flush and occupancy.
// Optional forwarding compare is enabled by defining WB_PIPE_FWD_EN; otherwise fwd_hit/fwd_data read 0.
module wb_pipe_buffer #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [REG_AW-1:0]          in_opa_adr,
    input  logic                       in_reg_we,
    input  logic [REG_AW-1:0]          in_dest_reg,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_result,
    output logic [REG_AW-1:0]          out_opa_adr,
    output logic                       out_reg_we,
    output logic [REG_AW-1:0]          out_dest_reg,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    input  logic [REG_AW-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("wb_pipe_buffer: DEPTH must be at least 1");
    end

    typedef struct packed {
        logic              valid;
        logic              reg_we;
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] opa_adr;
        logic [REG_AW-1:0] dest_reg;
    } stage_t;

    // stage_q[0] is the youngest bundle, stage_q[DEPTH-1] the oldest.
    stage_t            stage_q [DEPTH];
    stage_t            in_stage;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_shift;

    // A bubble carries all-zero fields so nothing stale leaks downstream.
    always_comb begin
        in_stage = '0;
        if (in_valid) begin
            in_stage.valid    = 1'b1;
            in_stage.reg_we   = in_reg_we;
            in_stage.result   = in_result;
            in_stage.opa_adr  = in_opa_adr;
            in_stage.dest_reg = in_dest_reg;
        end
    end

    // Occupancy after a shift: the incoming valid plus every stage that moves down.
    always_comb begin
        occ_shift = OCC_W'(in_valid);
        for (int k = 0; k < DEPTH - 1; k++) begin
            occ_shift = occ_shift + OCC_W'(stage_q[k].valid);
        end
    end

    // NOTE: state updates use non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            occ_q <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            occ_q <= '0;
        end else if (!stall) begin
            stage_q[0] <= in_stage;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
            occ_q <= occ_shift;
        end
    end

    assign out_valid    = stage_q[DEPTH-1].valid;
    assign out_result   = stage_q[DEPTH-1].result;
    assign out_opa_adr  = stage_q[DEPTH-1].opa_adr;
    assign out_reg_we   = stage_q[DEPTH-1].reg_we & stage_q[DEPTH-1].valid;
    assign out_dest_reg = stage_q[DEPTH-1].dest_reg;
    assign occupancy    = occ_q;

`ifdef WB_PIPE_FWD_EN
    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stage_q[k].valid && stage_q[k].reg_we && (stage_q[k].dest_reg == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = stage_q[k].result;
            end
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_buffer.sv
// Scoreboard bench for wb_pipe_buffer (DEPTH=2): driver queues expected bundles, a negedge monitor checks them.
// Forwarding expectations follow WB_PIPE_FWD_EN the same way the design does.
module tb_wb_pipe_buffer;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;
    localparam int DEPTH  = 2;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_result = '0;
    logic [REG_AW-1:0] in_opa_adr = '0;
    logic              in_reg_we = 1'b0;
    logic [REG_AW-1:0] in_dest_reg = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [REG_AW-1:0] out_opa_adr;
    logic              out_reg_we;
    logic [REG_AW-1:0] out_dest_reg;
    logic [OCC_W-1:0]  occupancy;
    logic [REG_AW-1:0] fwd_addr = '0;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] opa_adr;
        logic              reg_we;
        logic [REG_AW-1:0] dest_reg;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic shifted  = 1'b0;

    wb_pipe_buffer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_result(in_result), .in_opa_adr(in_opa_adr),
        .in_reg_we(in_reg_we), .in_dest_reg(in_dest_reg),
        .out_valid(out_valid), .out_result(out_result), .out_opa_adr(out_opa_adr),
        .out_reg_we(out_reg_we), .out_dest_reg(out_dest_reg), .occupancy(occupancy),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; a bundle that will actually enter the pipe is queued as expected output.
    task automatic drive(input logic v, input logic [DATA_W-1:0] res, input logic [REG_AW-1:0] opa,
                         input logic we, input logic [REG_AW-1:0] dest, input logic st, input logic fl);
        in_valid    = v;
        in_result   = res;
        in_opa_adr  = opa;
        in_reg_we   = we;
        in_dest_reg = dest;
        stall       = st;
        flush       = fl;
        if (v && !st && !fl) sb_q.push_back('{result: res, opa_adr: opa, reg_we: we, dest_reg: dest});
        @(posedge clk);
        #1;
        if (fl) sb_q.delete();
    endtask

    task automatic idle();
        drive(1'b0, 8'hEE, 3'd7, 1'b1, 3'd7, 1'b0, 1'b0);
    endtask

    always @(posedge clk) shifted = !stall && !flush && !rst;

    // Monitor: every shift either presents the next queued bundle or a fully zeroed bubble.
    always @(negedge clk) begin
        if (!rst) begin
            check("occ_bound", 32'(occupancy <= OCC_W'(DEPTH)), 32'd1);
            if (shifted && out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got result 0x%0h with no bundle expected at %0t", out_result, $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_result", 32'(out_result), 32'(e.result));
                    check("sb_opa", 32'(out_opa_adr), 32'(e.opa_adr));
                    check("sb_we", 32'(out_reg_we), 32'(e.reg_we));
                    check("sb_dest", 32'(out_dest_reg), 32'(e.dest_reg));
                end
            end else if (shifted) begin
                check("bubble_we", 32'(out_reg_we), 32'd0);
                check("bubble_result", 32'(out_result), 32'd0);
            end
        end
    end

    task automatic check_fwd(input string name, input logic [DATA_W-1:0] data_on);
`ifdef WB_PIPE_FWD_EN
        check({name, "_hit"}, 32'(fwd_hit), 32'(data_on != 0));
        check({name, "_data"}, 32'(fwd_data), 32'(data_on));
`else
        check({name, "_hit"}, 32'(fwd_hit), 32'd0);
        check({name, "_data"}, 32'(fwd_data), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        rst = 1'b0;

        // Latency: bundle appears exactly two edges later.
        drive(1'b1, 8'h5A, 3'd1, 1'b1, 3'd3, 1'b0, 1'b0);
        check("lat_early_valid", 32'(out_valid), 32'd0);
        check("lat_occ1", 32'(occupancy), 32'd1);
        idle();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_result", 32'(out_result), 32'h5A);
        check("lat_we", 32'(out_reg_we), 32'd1);
        check("lat_occ_tail", 32'(occupancy), 32'd1);
        idle();
        check("lat_occ_empty", 32'(occupancy), 32'd0);

        // Stall holds the pipe; the bundle offered during stall is dropped.
        drive(1'b1, 8'h11, 3'd2, 1'b1, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 3'd2, 1'b1, 3'd2, 1'b0, 1'b0);
        check("stall_pre_occ", 32'(occupancy), 32'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h33, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0);
            check("stall_hold_result", 32'(out_result), 32'h11);
            check("stall_hold_occ", 32'(occupancy), 32'd2);
        end
        idle();
        check("stall_next", 32'(out_result), 32'h22);
        idle();
        check("stall_lost_valid", 32'(out_valid), 32'd0);
        check("stall_lost_occ", 32'(occupancy), 32'd0);

        // Flush wins over stall.
        drive(1'b1, 8'h44, 3'd4, 1'b1, 3'd4, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 3'd5, 1'b1, 3'd5, 1'b0, 1'b0);
        check("flush_pre_occ", 32'(occupancy), 32'd2);
        drive(1'b1, 8'h66, 3'd6, 1'b1, 3'd6, 1'b1, 1'b1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_we", 32'(out_reg_we), 32'd0);
        check("flush_occ", 32'(occupancy), 32'd0);
        idle();
        check("flush_after_valid", 32'(out_valid), 32'd0);

        // Bubble in the middle of a stream.
        drive(1'b1, 8'h71, 3'd1, 1'b1, 3'd5, 1'b0, 1'b0);
        drive(1'b0, 8'h72, 3'd2, 1'b1, 3'd6, 1'b0, 1'b0);
        check("bub_we0", 32'(out_reg_we), 32'd1);
        drive(1'b1, 8'h73, 3'd3, 1'b1, 3'd7, 1'b0, 1'b0);
        check("bub_we1", 32'(out_reg_we), 32'd0);
        check("bub_occ", 32'(occupancy), 32'd1);
        idle();
        check("bub_we2", 32'(out_reg_we), 32'd1);
        check("bub_res2", 32'(out_result), 32'h73);
        idle();

        // Forwarding: youngest writing match wins, held through a stall.
        drive(1'b1, 8'h10, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0);
        drive(1'b1, 8'h20, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0);
        fwd_addr = 3'd4;
        #1;
        check_fwd("fwd_young", 8'h20);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        check_fwd("fwd_stall", 8'h20);
        fwd_addr = 3'd5;
        #1;
        check_fwd("fwd_miss", 8'h00);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        drive(1'b1, 8'h10, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0);
        drive(1'b1, 8'h20, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);
        fwd_addr = 3'd4;
        #1;
        check_fwd("fwd_old", 8'h10);
        idle();
        idle();

        // Asynchronous reset mid-stream with two valid bundles.
        drive(1'b1, 8'h81, 3'd1, 1'b1, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 8'h82, 3'd2, 1'b1, 3'd2, 1'b0, 1'b0);
        check("mid_pre_occ", 32'(occupancy), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_result", 32'(out_result), 32'd0);
        check("mid_we", 32'(out_reg_we), 32'd0);
        check("mid_dest", 32'(out_dest_reg), 32'd0);
        check("mid_occ", 32'(occupancy), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 8'h90, 3'd3, 1'b1, 3'd6, 1'b0, 1'b0);
        check("post_rst_early", 32'(out_valid), 32'd0);
        idle();
        check("post_rst_result", 32'(out_result), 32'h90);
        idle();
        idle();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
